interp_div_pipe: RTL and testbench

- Pipelined, parametrised constant-reciprocal scaler for the channel-estimation interpolation chain.
- Scales an I/Q pair of adder outputs by a run-time selectable weight (x1, x1/3, x2/3, x1/2) using multiply-by-constant plus shift.
- Rounds to nearest and saturates to the output width.
- Sits between the interpolation adders and the estimate buffer, with valid/ready flow control and a sticky overflow flag.

---
 rtl/interp_div_pipe.sv | 124 ++++++++++++
 tb/tb_interp_div_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_div_pipe.sv
// Three-stage I/Q scaler: multiply by a mode-selected reciprocal constant, then
// round half up, shift by FRAC_BITS and saturate. Global-enable valid/ready stall.
module interp_div_pipe #(
  parameter int IN_WIDTH   = 20,
  parameter int OUT_WIDTH  = 17,
  parameter int FRAC_BITS  = 6,
  parameter int PROD_WIDTH = IN_WIDTH + FRAC_BITS + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_i,
  input  logic signed [IN_WIDTH-1:0]  in_q,
  input  logic [1:0]                  mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_i,
  output logic signed [OUT_WIDTH-1:0] out_q,
  output logic                        ovf_sticky,
  input  logic                        ovf_clr
);

  localparam int KW = FRAC_BITS + 2;
  localparam logic signed [KW-1:0] K1  = KW'(2 ** FRAC_BITS);
  localparam logic signed [KW-1:0] K3  = KW'((2 ** FRAC_BITS + 1) / 3);
  localparam logic signed [KW-1:0] K23 = KW'((2 ** (FRAC_BITS + 1) + 1) / 3);
  localparam logic signed [KW-1:0] K2  = KW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [PROD_WIDTH-1:0] RND     = PROD_WIDTH'(2 ** (FRAC_BITS - 1));
  localparam logic signed [PROD_WIDTH-1:0] SAT_MAX = PROD_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [PROD_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic                          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [IN_WIDTH-1:0]    i1_q, i1_d, q1_q, q1_d;
  logic signed [KW-1:0]          k1_q, k1_d;
  logic signed [PROD_WIDTH-1:0]  pi2_q, pi2_d, pq2_q, pq2_d;
  logic signed [OUT_WIDTH-1:0]   oi_q, oi_d, oq_q, oq_d;
  logic                          ovf_q, ovf_d;
  logic                          en;
  logic [OUT_WIDTH:0]            ri, rq;

  // Returns {saturated, result}; the sum cannot overflow PROD_WIDTH since |K| <= 2^F.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [PROD_WIDTH-1:0] prod);
    logic signed [PROD_WIDTH-1:0] shifted;
    shifted = (prod + RND) >>> FRAC_BITS;
    if (shifted > SAT_MAX)      round_sat = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (shifted < SAT_MIN) round_sat = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else                        round_sat = {1'b0, shifted[OUT_WIDTH-1:0]};
  endfunction

  always_comb begin
    en    = !v3_q || out_ready;
    ri    = round_sat(pi2_q);
    rq    = round_sat(pq2_q);
    v1_d  = v1_q;
    i1_d  = i1_q;
    q1_d  = q1_q;
    k1_d  = k1_q;
    v2_d  = v2_q;
    pi2_d = pi2_q;
    pq2_d = pq2_q;
    v3_d  = v3_q;
    oi_d  = oi_q;
    oq_d  = oq_q;
    if (en) begin
      v1_d = in_valid;
      i1_d = in_i;
      q1_d = in_q;
      case (mode)
        2'd0:    k1_d = K1;
        2'd1:    k1_d = K3;
        2'd2:    k1_d = K23;
        default: k1_d = K2;
      endcase
      v2_d  = v1_q;
      pi2_d = PROD_WIDTH'(i1_q) * PROD_WIDTH'(k1_q);
      pq2_d = PROD_WIDTH'(q1_q) * PROD_WIDTH'(k1_q);
      v3_d  = v2_q;
      // Output data only moves for real samples so a bubble never disturbs it.
      if (v2_q) begin
        oi_d = ri[OUT_WIDTH-1:0];
        oq_d = rq[OUT_WIDTH-1:0];
      end
    end
    if (en && v2_q && (ri[OUT_WIDTH] || rq[OUT_WIDTH])) ovf_d = 1'b1;
    else if (ovf_clr)                                  ovf_d = 1'b0;
    else                                               ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      i1_q  <= '0;
      q1_q  <= '0;
      k1_q  <= '0;
      pi2_q <= '0;
      pq2_q <= '0;
      oi_q  <= '0;
      oq_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      i1_q  <= i1_d;
      q1_q  <= q1_d;
      k1_q  <= k1_d;
      pi2_q <= pi2_d;
      pq2_q <= pq2_d;
      oi_q  <= oi_d;
      oq_q  <= oq_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready   = en;
  assign out_valid  = v3_q;
  assign out_i      = oi_q;
  assign out_q      = oq_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_interp_div_pipe.sv
// Bench for interp_div_pipe: directed latency/rounding/saturation/stall/reset cases
// plus a randomized stream scored against an arithmetic reference model.
module tb_interp_div_pipe;
  localparam int IN_W  = 20;
  localparam int OUT_W = 17;
  localparam int F     = 6;

  logic                    clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic                    ovf_sticky, ovf_clr;
  logic signed [IN_W-1:0]  in_i, in_q;
  logic [1:0]              mode;
  logic signed [OUT_W-1:0] out_i, out_q;

  int     n_chk = 0;
  int     n_err = 0;
  int     n_out = 0;
  longint exp_i_q[$];
  longint exp_q_q[$];
  logic                    hold_v = 1'b0;
  logic signed [OUT_W-1:0] hold_i, hold_q;
  bit                      rnd_done;

  interp_div_pipe #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .FRAC_BITS(F)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Weight as a fraction x*w/2^F, rounded half toward +inf, then clamped.
  function automatic longint ref_scale(input longint x, input int m);
    longint w, d, n, r, hi, lo;
    d = 64'(2 ** F);
    case (m)
      0:       w = d;
      1:       w = (d + 1) / 3;
      2:       w = (2 * d + 1) / 3;
      default: w = d / 2;
    endcase
    n = x * w + d / 2;
    r = n / d;
    if ((n % d) != 0 && n < 0) r = r - 1;
    hi = 64'(2 ** (OUT_W - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted inputs go through the model, delivered outputs are popped.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_i_q.delete();
      exp_q_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_i", out_i, hold_i);
        chk("hold_q", out_q, hold_q);
      end
      hold_v = out_valid && !out_ready;
      hold_i = out_i;
      hold_q = out_q;
      if (out_valid && out_ready) begin
        if (exp_i_q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          chk("sb_i", out_i, exp_i_q.pop_front());
          chk("sb_q", out_q, exp_q_q.pop_front());
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_i_q.push_back(ref_scale(longint'(in_i), int'(mode)));
        exp_q_q.push_back(ref_scale(longint'(in_q), int'(mode)));
      end
    end
  end

  task automatic single(input int i, input int q, input int m, input longint ei);
    in_i = IN_W'(i); in_q = IN_W'(q); mode = 2'(m); in_valid = 1'b1;
    @(negedge clk);
    chk("single_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c < 3) chk("single_early_v", out_valid, 0);
      else begin
        chk("single_v", out_valid, 1);
        chk("single_i", out_i, ei);
        chk("single_q", out_q, ref_scale(longint'(q), m));
      end
      tick();
    end
    @(negedge clk);
    chk("single_v_drop", out_valid, 0);
    tick();
  endtask

  task automatic sat_sample(input bit clr_same);
    in_i = IN_W'(524287); in_q = IN_W'(-524288); mode = 2'd0; in_valid = 1'b1;
    @(negedge clk); tick();
    in_valid = 1'b0;
    @(negedge clk); tick();
    ovf_clr = clr_same;
    @(negedge clk); tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("sat_v", out_valid, 1);
    chk("sat_i", out_i, 65535);
    chk("sat_q", out_q, -65536);
    chk("sat_ovf", ovf_sticky, 1);
    tick();
  endtask

  task automatic send(input int i, input int q, input int m);
    int c;
    in_i = IN_W'(i); in_q = IN_W'(q); mode = 2'(m); in_valid = 1'b1;
    c = 0;
    @(negedge clk);
    while (!in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (exp_i_q.size() != 0 && c < 50) begin
      tick();
      c++;
    end
    chk(tag, exp_i_q.size(), 0);
  endtask

  initial begin
    int sweep_exp[4];
    int base;
    sweep_exp = '{300, 98, 202, 150};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    in_i = '0; in_q = '0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_ready", in_ready, 1);
    tick();

    single(300, -300, 1, 98);

    for (int t = 0; t < 7; t++) begin
      in_valid = (t < 4);
      in_i = IN_W'(300); in_q = IN_W'(-7 * t); mode = 2'(t);
      @(negedge clk);
      chk("sweep_rdy", in_ready, 1);
      if (t >= 3) begin
        chk("sweep_v", out_valid, 1);
        chk("sweep_i", out_i, sweep_exp[t-3]);
      end
      tick();
    end
    in_valid = 1'b0;

    single(-1, 5, 1, 0);
    single(3, -5, 1, 1);
    single(-3, 1, 1, -1);
    single(-100, 101, 2, -67);
    chk("ovf_pre", ovf_sticky, 0);

    sat_sample(1'b0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    @(negedge clk); chk("ovf_clr", ovf_sticky, 0); tick();
    sat_sample(1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    @(negedge clk); chk("ovf_clr2", ovf_sticky, 0); tick();

    base = n_out;
    fork
      begin
        for (int k = 0; k < 6; k++) send(1000 * k - 2500, 77 * k, k % 4);
      end
      begin
        int c;
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 20) begin
          @(negedge clk);
          c++;
        end
        chk("bp_wait", out_valid, 1);
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          chk("bp_rdy", in_ready, 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", n_out - base, 6);

    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_i = IN_W'(100 * (k + 1)); in_q = IN_W'(-50 * k); mode = 2'(k);
      @(negedge clk);
      tick();
    end
    in_valid = 1'b0;
    chk("rst_mid_pre_v", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_v", out_valid, 0);
    chk("rst_mid_i", out_i, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_no_stale", out_valid, 0);
    end
    tick();

    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          int gi, gq, gap;
          if ($urandom_range(0, 1) == 1) begin
            gi = int'({{12{1'b0}}, IN_W'($urandom())}) - (1 << (IN_W - 1));
            gq = int'({{12{1'b0}}, IN_W'($urandom())}) - (1 << (IN_W - 1));
          end else begin
            gi = int'($urandom_range(0, 4000)) - 2000;
            gq = int'($urandom_range(0, 4000)) - 2000;
          end
          gap = int'($urandom_range(0, 2));
          for (int g = 0; g < gap; g++) tick();
          send(gi, gq, int'($urandom_range(0, 3)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain("rnd_drain");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
